// File: rtl/cr_sa_param_core.sv
// Parameterised statistics counter array: selectable event per counter,
// wrap/saturate modes, sticky overflow, snapshot with optional clear-on-snapshot.
module cr_sa_param_core #(
   parameter int unsigned N_CNT = 64,
   parameter int unsigned CNT_W = 50,
   parameter int unsigned N_EVT = 256,
   parameter int unsigned SEL_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_EVT-1:0]         stat_events,
   input  logic                     regs_sa_snap,
   input  logic                     regs_sa_clear_live,
   input  logic [N_CNT*SEL_W-1:0]   regs_sa_sel,
   input  logic [N_CNT-1:0]         regs_sa_en,
   input  logic [N_CNT-1:0]         regs_sa_sat,
   input  logic [N_CNT-1:0]         regs_sa_snap_clr,
   output logic [N_CNT*CNT_W-1:0]   sa_count,
   output logic [N_CNT*CNT_W-1:0]   sa_snapshot,
   output logic [N_CNT-1:0]         sa_ovf,
   output logic                     sa_snap_done
);

   localparam int unsigned EXT_W = 1 << SEL_W;

   logic [N_EVT-1:0] evt_q;
   logic [EXT_W-1:0] evt_ext;
   logic [CNT_W-1:0] cnt_q  [N_CNT];
   logic [CNT_W-1:0] cnt_d  [N_CNT];
   logic [CNT_W-1:0] snap_q [N_CNT];
   logic [CNT_W-1:0] snap_d [N_CNT];
   logic [N_CNT-1:0] ovf_q;
   logic [N_CNT-1:0] ovf_d;
   logic [N_CNT-1:0] inc;
   logic             done_q;

   // Zero-padded to the full select range so out-of-range selects read 0.
   always_comb begin
      evt_ext = '0;
      evt_ext[N_EVT-1:0] = evt_q;
   end

   always_comb begin
      inc = '0;
      ovf_d = ovf_q;
      for (int unsigned i = 0; i < N_CNT; i++) begin
         inc[i]    = regs_sa_en[i] & evt_ext[regs_sa_sel[i*SEL_W +: SEL_W]];
         cnt_d[i]  = cnt_q[i];
         snap_d[i] = regs_sa_snap ? cnt_q[i] : snap_q[i];
         if (regs_sa_clear_live) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (regs_sa_snap && regs_sa_snap_clr[i]) begin
            cnt_d[i] = CNT_W'(inc[i]);
         end else if (inc[i]) begin
            if (&cnt_q[i]) begin
               ovf_d[i] = 1'b1;
               if (!regs_sa_sat[i]) begin
                  cnt_d[i] = '0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q  <= '0;
         ovf_q  <= '0;
         done_q <= 1'b0;
         for (int unsigned i = 0; i < N_CNT; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         evt_q  <= stat_events;
         ovf_q  <= ovf_d;
         done_q <= regs_sa_snap;
         for (int unsigned i = 0; i < N_CNT; i++) begin
            cnt_q[i]  <= cnt_d[i];
            snap_q[i] <= snap_d[i];
         end
      end
   end

   always_comb begin
      sa_count    = '0;
      sa_snapshot = '0;
      for (int unsigned i = 0; i < N_CNT; i++) begin
         sa_count[i*CNT_W +: CNT_W]    = cnt_q[i];
         sa_snapshot[i*CNT_W +: CNT_W] = snap_q[i];
      end
   end

   assign sa_ovf       = ovf_q;
   assign sa_snap_done = done_q;

endmodule

// File: tb/tb_cr_sa_param_core.sv
// Self-checking bench for cr_sa_param_core: directed scenarios plus a
// randomized run compared against a behavioural reference model.
module tb_cr_sa_param_core;

   localparam int NC   = 8;
   localparam int CW   = 8;
   localparam int NE   = 256;
   localparam int SW   = 9;
   localparam int MAXV = (1 << CW) - 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NE-1:0]      stat_events;
   logic               regs_sa_snap;
   logic               regs_sa_clear_live;
   logic [NC*SW-1:0]   regs_sa_sel;
   logic [NC-1:0]      regs_sa_en;
   logic [NC-1:0]      regs_sa_sat;
   logic [NC-1:0]      regs_sa_snap_clr;
   logic [NC*CW-1:0]   sa_count;
   logic [NC*CW-1:0]   sa_snapshot;
   logic [NC-1:0]      sa_ovf;
   logic               sa_snap_done;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [CW-1:0] m_cnt  [NC];
   logic [CW-1:0] m_snap [NC];
   logic [NC-1:0] m_ovf;
   logic          m_done;
   logic [NE-1:0] m_ev;

   cr_sa_param_core #(
      .N_CNT(NC), .CNT_W(CW), .N_EVT(NE), .SEL_W(SW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stat_events       (stat_events),
      .regs_sa_snap      (regs_sa_snap),
      .regs_sa_clear_live(regs_sa_clear_live),
      .regs_sa_sel       (regs_sa_sel),
      .regs_sa_en        (regs_sa_en),
      .regs_sa_sat       (regs_sa_sat),
      .regs_sa_snap_clr  (regs_sa_snap_clr),
      .sa_count          (sa_count),
      .sa_snapshot       (sa_snapshot),
      .sa_ovf            (sa_ovf),
      .sa_snap_done      (sa_snap_done)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] dut_cnt(int i);
      return sa_count[i*CW +: CW];
   endfunction

   function automatic logic [CW-1:0] dut_snap(int i);
      return sa_snapshot[i*CW +: CW];
   endfunction

   function automatic int sel_of(int i);
      return int'(regs_sa_sel[i*SW +: SW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_cnt[i]  = '0;
         m_snap[i] = '0;
      end
      m_ovf  = '0;
      m_done = 1'b0;
      m_ev   = '0;
   endtask

   // One clock of the documented behaviour, evaluated on the inputs present before the edge.
   task automatic model_step();
      for (int i = 0; i < NC; i++) begin
         bit hit;
         int nxt;
         hit = regs_sa_en[i] && (sel_of(i) < NE) && m_ev[sel_of(i)];
         if (regs_sa_snap) m_snap[i] = m_cnt[i];
         if (regs_sa_clear_live) begin
            m_cnt[i] = '0;
            m_ovf[i] = 1'b0;
         end else if (regs_sa_snap && regs_sa_snap_clr[i]) begin
            m_cnt[i] = hit ? CW'(1) : CW'(0);
         end else if (hit) begin
            nxt = int'(m_cnt[i]) + 1;
            if (nxt > MAXV) begin
               m_ovf[i] = 1'b1;
               nxt = regs_sa_sat[i] ? MAXV : nxt % (MAXV + 1);
            end
            m_cnt[i] = CW'(nxt);
         end
      end
      m_done = regs_sa_snap;
      m_ev   = stat_events;
   endtask

   task automatic tick();
      if (!rst_n) model_reset();
      else        model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_idle();
      regs_sa_en = '0; regs_sa_sat = '0; regs_sa_snap_clr = '0; regs_sa_sel = '0;
      regs_sa_snap = 1'b0; regs_sa_clear_live = 1'b0; stat_events = '0;
   endtask

   task automatic set_cfg(int i, int sel, bit en, bit sat, bit sclr);
      regs_sa_sel[i*SW +: SW] = SW'(sel);
      regs_sa_en[i]       = en;
      regs_sa_sat[i]      = sat;
      regs_sa_snap_clr[i] = sclr;
   endtask

   task automatic clear_tick();
      regs_sa_clear_live = 1'b1;
      tick();
      regs_sa_clear_live = 1'b0;
   endtask

   task automatic test_reset();
      regs_sa_snap = 1'b1; regs_sa_clear_live = 1'b1;
      stat_events = '1; regs_sa_en = '1;
      repeat (3) tick();
      checks++;
      if (sa_count !== '0 || sa_snapshot !== '0 || sa_ovf !== '0 || sa_snap_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold cnt=%h snap=%h ovf=%h done=%b expected all 0",
                  sa_count, sa_snapshot, sa_ovf, sa_snap_done);
      end
      cfg_idle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (sa_count !== '0 || sa_snap_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release cnt=%h done=%b expected 0", sa_count, sa_snap_done);
      end
      tick();
      checks++;
      if (sa_count !== '0 || sa_ovf !== '0 || sa_snap_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_edge cnt=%h ovf=%h done=%b expected 0", sa_count, sa_ovf, sa_snap_done);
      end
   endtask

   task automatic test_basic_count();
      logic [CW-1:0] exp_seq [5];
      exp_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
      cfg_idle();
      set_cfg(0, 5, 1'b1, 1'b0, 1'b0);
      clear_tick();
      stat_events[5] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 3) stat_events[5] = 1'b0;
         tick();
         checks++;
         if (dut_cnt(0) !== exp_seq[k]) begin
            errors++;
            $display("FAIL basic_count step%0d got %0d expected %0d", k, dut_cnt(0), exp_seq[k]);
         end
      end
   endtask

   task automatic test_overflow();
      cfg_idle();
      set_cfg(1, 10, 1'b1, 1'b0, 1'b0);
      clear_tick();
      stat_events[10] = 1'b1;
      repeat (256) tick();
      checks++;
      if (dut_cnt(1) !== 8'd255 || sa_ovf[1] !== 1'b0) begin
         errors++;
         $display("FAIL wrap_preload got %0d ovf=%b expected 255 ovf=0", dut_cnt(1), sa_ovf[1]);
      end
      stat_events[10] = 1'b0;
      tick();
      checks++;
      if (dut_cnt(1) !== 8'd0 || sa_ovf[1] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_ovf got %0d ovf=%b expected 0 ovf=1", dut_cnt(1), sa_ovf[1]);
      end
      regs_sa_sat[1] = 1'b1;
      clear_tick();
      checks++;
      if (sa_ovf[1] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear_live got %b expected 0", sa_ovf[1]);
      end
      stat_events[10] = 1'b1;
      repeat (256) tick();
      stat_events[10] = 1'b0;
      tick();
      tick();
      checks++;
      if (dut_cnt(1) !== 8'd255 || sa_ovf[1] !== 1'b1) begin
         errors++;
         $display("FAIL sat_hold got %0d ovf=%b expected 255 ovf=1", dut_cnt(1), sa_ovf[1]);
      end
   endtask

   task automatic test_snap_clr();
      cfg_idle();
      set_cfg(2, 20, 1'b1, 1'b0, 1'b1);
      clear_tick();
      stat_events[20] = 1'b1;
      repeat (8) tick();
      checks++;
      if (dut_cnt(2) !== 8'd7 || sa_snap_done !== 1'b0) begin
         errors++;
         $display("FAIL snapclr_pre got %0d done=%b expected 7 done=0", dut_cnt(2), sa_snap_done);
      end
      stat_events[20] = 1'b0;
      regs_sa_snap = 1'b1;
      tick();
      regs_sa_snap = 1'b0;
      checks++;
      if (dut_snap(2) !== 8'd7 || dut_cnt(2) !== 8'd1 || sa_snap_done !== 1'b1) begin
         errors++;
         $display("FAIL snapclr_edge snap=%0d cnt=%0d done=%b expected 7 1 1",
                  dut_snap(2), dut_cnt(2), sa_snap_done);
      end
      tick();
      checks++;
      if (sa_snap_done !== 1'b0 || dut_cnt(2) !== 8'd1 || dut_snap(2) !== 8'd7) begin
         errors++;
         $display("FAIL snapclr_after done=%b cnt=%0d snap=%0d expected 0 1 7",
                  sa_snap_done, dut_cnt(2), dut_snap(2));
      end
   endtask

   task automatic test_clear_with_snap();
      cfg_idle();
      set_cfg(3, 30, 1'b1, 1'b0, 1'b0);
      clear_tick();
      stat_events[30] = 1'b1;
      repeat (277) tick();
      checks++;
      if (dut_cnt(3) !== 8'd20 || sa_ovf[3] !== 1'b1) begin
         errors++;
         $display("FAIL clrsnap_pre cnt=%0d ovf=%b expected 20 1", dut_cnt(3), sa_ovf[3]);
      end
      stat_events[30] = 1'b0;
      regs_sa_snap = 1'b1;
      regs_sa_clear_live = 1'b1;
      tick();
      regs_sa_snap = 1'b0;
      regs_sa_clear_live = 1'b0;
      checks++;
      if (dut_snap(3) !== 8'd20 || dut_cnt(3) !== 8'd0 || sa_ovf[3] !== 1'b0 || sa_snap_done !== 1'b1) begin
         errors++;
         $display("FAIL clrsnap_edge snap=%0d cnt=%0d ovf=%b done=%b expected 20 0 0 1",
                  dut_snap(3), dut_cnt(3), sa_ovf[3], sa_snap_done);
      end
      tick();
      checks++;
      if (dut_cnt(3) !== 8'd0) begin
         errors++;
         $display("FAIL clrsnap_discard cnt=%0d expected 0", dut_cnt(3));
      end
   endtask

   task automatic test_sel_range();
      cfg_idle();
      set_cfg(4, 300, 1'b1, 1'b0, 1'b0);
      set_cfg(0, 77, 1'b1, 1'b0, 1'b0);
      set_cfg(5, 77, 1'b1, 1'b0, 1'b0);
      set_cfg(6, 77, 1'b1, 1'b0, 1'b0);
      set_cfg(7, 77, 1'b1, 1'b0, 1'b0);
      clear_tick();
      stat_events = '1;
      repeat (100) tick();
      stat_events = '0;
      tick();
      checks++;
      if (dut_cnt(4) !== 8'd0) begin
         errors++;
         $display("FAIL sel_out_of_range got %0d expected 0", dut_cnt(4));
      end
      for (int i = 0; i < NC; i++) begin
         if (i == 0 || i >= 5) begin
            checks++;
            if (dut_cnt(i) !== 8'd100) begin
               errors++;
               $display("FAIL shared_sel cnt%0d got %0d expected 100", i, dut_cnt(i));
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      cfg_idle();
      set_cfg(0, 5, 1'b1, 1'b0, 1'b0);
      clear_tick();
      stat_events[5] = 1'b1;
      tick();
      tick();
      checks++;
      if (dut_cnt(0) !== 8'd1) begin
         errors++;
         $display("FAIL midflight_pre got %0d expected 1", dut_cnt(0));
      end
      #2;
      rst_n = 1'b0;
      stat_events = '0;
      #1;
      checks++;
      if (sa_count !== '0 || sa_snapshot !== '0 || sa_ovf !== '0 || sa_snap_done !== 1'b0) begin
         errors++;
         $display("FAIL midflight_async cnt=%h snap=%h ovf=%h done=%b expected all 0",
                  sa_count, sa_snapshot, sa_ovf, sa_snap_done);
      end
      model_reset();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (sa_count !== '0) begin
         errors++;
         $display("FAIL midflight_release cnt=%h expected 0", sa_count);
      end
   endtask

   task automatic test_random();
      cfg_idle();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 40 == 0) begin
            for (int i = 0; i < NC; i++)
               set_cfg(i, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 511),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         end
         for (int b = 0; b < NE; b++) stat_events[b] = ($urandom_range(0, 2) != 0);
         regs_sa_snap       = ($urandom_range(0, 19) == 0);
         regs_sa_clear_live = ($urandom_range(0, 299) == 0);
         tick();
         for (int i = 0; i < NC; i++) begin
            checks++;
            if (dut_cnt(i) !== m_cnt[i] || dut_snap(i) !== m_snap[i]) begin
               errors++;
               $display("FAIL rand_cnt cyc%0d cnt%0d got %0d/%0d expected %0d/%0d",
                        cyc, i, dut_cnt(i), dut_snap(i), m_cnt[i], m_snap[i]);
            end
         end
         checks++;
         if (sa_ovf !== m_ovf || sa_snap_done !== m_done) begin
            errors++;
            $display("FAIL rand_flags cyc%0d ovf=%b done=%b expected %b %b",
                     cyc, sa_ovf, sa_snap_done, m_ovf, m_done);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_idle();
      model_reset();
      test_reset();
      test_basic_count();
      test_overflow();
      test_snap_clr();
      test_clear_with_snap();
      test_sel_range();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
